// File: rtl/bp_fe_bp_trace_driver.sv
// rtl/bp_fe_bp_trace_driver.sv - replays resolved branch records into a predictor and tallies mispredictions
module bp_fe_bp_trace_driver #(
    parameter int bht_idx_width_p = 8,
    parameter int cnt_width_p     = 32
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,

    input  logic                       trace_v_i,
    input  logic [bht_idx_width_p-1:0] trace_idx_i,
    input  logic                       trace_taken_i,
    output logic                       trace_ready_o,

    output logic                       r_v_o,
    output logic [bht_idx_width_p-1:0] idx_r_o,
    input  logic                       predict_i,

    output logic                       w_v_o,
    output logic [bht_idx_width_p-1:0] idx_w_o,
    output logic                       correct_o,
    output logic                       mispredict_o,

    input  logic                       stat_clear_i,
    output logic [cnt_width_p-1:0]     branch_cnt_o,
    output logic [cnt_width_p-1:0]     miss_cnt_o,
    output logic                       busy_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PREDICT = 2'd1,
        S_UPDATE  = 2'd2
    } state_e;

    localparam logic [cnt_width_p-1:0] CNT_MAX = '1;

    state_e                       state_q, state_d;
    logic [bht_idx_width_p-1:0]   idx_q, idx_d;
    logic                         taken_q, taken_d;
    logic                         pred_q, pred_d;
    logic [cnt_width_p-1:0]       branch_cnt_q, branch_cnt_d;
    logic [cnt_width_p-1:0]       miss_cnt_q, miss_cnt_d;
    logic                         accept;
    logic                         correct;

    assign accept  = trace_v_i && (state_q == S_IDLE);
    assign correct = (state_q == S_UPDATE) && (pred_q == taken_q);

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // One record at a time: the read must observe predictor state before this record's update.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (accept) state_d = S_PREDICT;
            S_PREDICT: state_d = S_UPDATE;
            S_UPDATE:  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        trace_ready_o = (state_q == S_IDLE);
        r_v_o         = (state_q == S_PREDICT);
        w_v_o         = (state_q == S_UPDATE);
        busy_o        = (state_q != S_IDLE);
        correct_o     = correct;
        mispredict_o  = (state_q == S_UPDATE) && !correct;
        idx_r_o       = idx_q;
        idx_w_o       = idx_q;
        branch_cnt_o  = branch_cnt_q;
        miss_cnt_o    = miss_cnt_q;
    end

    always_comb begin
        idx_d   = idx_q;
        taken_d = taken_q;
        pred_d  = pred_q;
        if (accept) begin
            idx_d   = trace_idx_i;
            taken_d = trace_taken_i;
        end
        if (state_q == S_PREDICT) begin
            pred_d = predict_i;
        end
    end

    // Saturating tallies; a clear in the same cycle as an update discards that update.
    always_comb begin
        branch_cnt_d = branch_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        if (stat_clear_i) begin
            branch_cnt_d = '0;
            miss_cnt_d   = '0;
        end else if (state_q == S_UPDATE) begin
            if (branch_cnt_q != CNT_MAX) begin
                branch_cnt_d = branch_cnt_q + cnt_width_p'(1);
            end
            if (!correct && (miss_cnt_q != CNT_MAX)) begin
                miss_cnt_d = miss_cnt_q + cnt_width_p'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            idx_q        <= '0;
            taken_q      <= 1'b0;
            pred_q       <= 1'b0;
            branch_cnt_q <= '0;
            miss_cnt_q   <= '0;
        end else begin
            idx_q        <= idx_d;
            taken_q      <= taken_d;
            pred_q       <= pred_d;
            branch_cnt_q <= branch_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

endmodule

// File: doc/bp_fe_bp_trace_driver.md
# bp_fe_bp_trace_driver

Initiator that drives the update/read port of a branch-direction predictor (bimodal, gselect, or any predictor exposing the `w_v/idx_w/correct` + `r_v/idx_r/predict` interface) from a stream of resolved branch records. For each accepted record it issues one prediction read, compares the returned prediction against the recorded outcome, issues exactly one update carrying the correct/incorrect verdict, and accumulates branch and misprediction counts. It sits between the trace source (testbench FIFO or a front-end resolution stage) and the predictor under evaluation.

## Interface
- `bht_idx_width_p`, "inv", width of the predictor index; must match the attached predictor.
- `cnt_width_p`, 32, width of the branch and misprediction counters.
- `clk_i  in  1`  clock; all state updates on the rising edge.
- `reset_n_i  in  1`  synchronous, active-low reset.
- `trace_v_i  in  1`  trace record valid.
- `trace_idx_i  in  bht_idx_width_p`  branch index (PC-derived) of the record.
- `trace_taken_i  in  1`  resolved direction: 1 = taken.
- `trace_ready_o  out  1`  block can accept a record this cycle.
- `r_v_o  out  1`  prediction read valid, to predictor `r_v_i`.
- `idx_r_o  out  bht_idx_width_p`  read index, to predictor `idx_r_i`.
- `predict_i  in  1`  prediction from predictor `predict_o`; combinational in the `r_v_o` cycle.
- `w_v_o  out  1`  update valid, to predictor `w_v_i`.
- `idx_w_o  out  bht_idx_width_p`  update index, to predictor `idx_w_i`.
- `correct_o  out  1`  1 = prediction matched outcome.
- `mispredict_o  out  1`  single-cycle pulse, high in an update cycle with `correct_o` = 0.
- `stat_clear_i  in  1`  synchronous clear of both counters.
- `branch_cnt_o  out  cnt_width_p`  records completed.
- `miss_cnt_o  out  cnt_width_p`  records mispredicted.
- `busy_o  out  1`  record in flight (state != IDLE).

## Operation
- FSM: IDLE -> PREDICT -> UPDATE -> IDLE; one record per 3 cycles; no overlap, because predictor history advances on update and the read must see pre-update state.
- IDLE: `trace_ready_o` = 1. On `trace_v_i & trace_ready_o`, capture `trace_idx_i` -> `idx_q`, `trace_taken_i` -> `taken_q`; go PREDICT. Otherwise stay.
- PREDICT: `r_v_o` = 1, `idx_r_o` = `idx_q`; register `predict_i` -> `pred_q`; go UPDATE unconditionally.
- UPDATE: `w_v_o` = 1, `idx_w_o` = `idx_q`, `correct_o` = (`pred_q` == `taken_q`), `mispredict_o` = ~`correct_o`; at edge: `branch_cnt` += 1, `miss_cnt` += ~`correct_o`; go IDLE.
- `r_v_o`, `w_v_o`, `mispredict_o`, `trace_ready_o` are decoded from state only; never high outside their state.
- `idx_r_o`, `idx_w_o` always drive `idx_q`; `correct_o` is 0 outside UPDATE.
- Counters saturate at all-ones; no wrap.
- `stat_clear_i` zeroes both counters at the edge; wins over a coincident UPDATE increment; the FSM is unaffected.

## Timing
- Reset (`reset_n_i` = 0 at an edge): state = IDLE, `idx_q` = 0, `taken_q` = 0, `pred_q` = 0, both counters 0. Outputs after reset: `trace_ready_o` = 1, `busy_o` = 0, `r_v_o` = `w_v_o` = `correct_o` = `mispredict_o` = 0, `idx_r_o` = `idx_w_o` = 0.
- Reset mid-record (PREDICT or UPDATE): the record is abandoned, no further `r_v_o`/`w_v_o` is issued for it, and counters are cleared.
- Handshake accepted at edge N: `r_v_o` high in cycle N+1, `w_v_o` high in cycle N+2, updated counters and `trace_ready_o` = 1 in cycle N+3; earliest next accept is edge N+3.
- `trace_v_i` during PREDICT or UPDATE is ignored (ready low); the source must hold the record.
- Predictor read is combinational: `predict_i` is sampled at the end of the PREDICT cycle only.

## Test plan
- Reset then idle: hold `reset_n_i` = 0 for 2 cycles, release, drive `trace_v_i` = 0 -> `trace_ready_o` = 1, all valids 0, counters 0.
- Single record idx 0x05, taken = 1, `predict_i` = 0 -> `r_v_o` at N+1 with `idx_r_o` = 0x05; `w_v_o` at N+2 with `idx_w_o` = 0x05, `correct_o` = 0, `mispredict_o` = 1; counts 1/1 at N+3.
- 4 back-to-back records (trace_v held high), predictor stub mirrors taken -> accepts at N, N+3, N+6, N+9 only; final counts 4/0; no `r_v_o`/`w_v_o` overlap.
- Counter saturation with `cnt_width_p` = 4: 17 mispredicted records -> both counts stop at 15.
- `stat_clear_i` asserted in the UPDATE cycle of record 3 after 2 completed records -> counts 0/0 the next cycle; FSM returns to IDLE normally.
- Reset asserted during PREDICT -> no `w_v_o` follows; IDLE, counters 0, `trace_ready_o` = 1 after the reset edge.
